cp0_exc: RTL
============

# cp0_exc

Coprocessor-0 exception controller for the five-stage MIPS pipeline. It detects overflow, syscall and external-interrupt events, captures the victim PC into EPC, and flushes IF/ID/EX. It redirects fetch to the handler vector and supplies EPC to the next-PC logic on ERET. It owns CP0 registers Status(12), Cause(13), EPC(14) and PRId(15) for MTC0/MFC0.

## Interface
- No parameters; all constants come from Para.v.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Ov_Req  in  1  arithmetic overflow on the EX-stage instruction
- Sys_Req  in  1  SYSCALL decoded in ID
- Ex_PC  in  32  PC of the EX-stage instruction
- Id_PC  in  32  PC of the ID-stage instruction
- Ex_BD  in  1  EX instruction sits in a branch delay slot
- Id_BD  in  1  ID instruction sits in a branch delay slot
- Int  in  6  level-sensitive external interrupt lines
- ERET  in  1  ERET decoded in ID
- Mtc0_En  in  1  MTC0 write strobe (ID)
- Cp0_Addr  in  5  CP0 register number for MTC0/MFC0
- Cp0_Wdata  in  32  MTC0 data
- Cp0_Rdata  out  32  MFC0 data, combinational from Cp0_Addr
- Exc_Take  out  1  one-cycle pulse: next-PC must select Exc_Vector
- Exc_Vector  out  32  constant `EXC_VECTOR
- Flush  out  1  clear IF/ID, ID/EX, EX/MEM valid bits (same cycle as Exc_Take)
- EPC  out  32  current EPC register, feeds next-PC ERET path
- Exl  out  1  Status.EXL

## Operation
- Registers:
  - Status: IE bit 0, EXL bit 1 (read-only to software), IM bits 15:10; other bits read 0.
  - Cause: ExcCode bits 6:2, IP bits 15:10 (live Int), BD bit 31; fully read-only.
  - EPC: read/write.
  - PRId: constant `CP0_PRID.
  - Writes to other addresses are ignored; reads of them return 0.
- Priority (oldest instruction wins):
  - Ov_Req: ExcCode 12, victim Ex_PC/Ex_BD.
  - Sys_Req: ExcCode 8, victim Id_PC/Id_BD.
  - Interrupt when IE & ~EXL & |(IP & IM): ExcCode 0, victim Ex_PC/Ex_BD; the EX instruction is flushed and re-executed.
- EPC capture: victim PC - 4 if BD, else victim PC. Cause.BD is set to the victim BD flag.
- State machine:
  - IDLE: EXL=0. On any request, go to TAKE.
  - TAKE: lasts one cycle. Exc_Take=Flush=1, EXL=1. Requests, ERET and MTC0 are ignored (those instructions are being flushed). Next state is HANDLER.
  - HANDLER: EXL=1, interrupts masked. On Ov_Req/Sys_Req, go to TAKE, but EPC and Cause.BD are not overwritten (ExcCode is updated). On ERET, go to IDLE and clear EXL.
- ERET in IDLE: treated as a no-op in CP0; next-PC still uses the EPC output.

## Timing
- Request sampled at edge N. At edge N+1:
  - State becomes TAKE; EPC, Cause and EXL are updated.
  - Exc_Take and Flush are high during cycle N+1 only.
  - Fetch from Exc_Vector occurs at edge N+2.
- ERET at edge N: EXL=0 from cycle N+1. EPC is stable and already valid at cycle N for the redirect.
- MTC0 takes effect at the next edge. MFC0 to the same register in the same cycle returns the old value.
- Simultaneous events:
  - Exception capture overrides an MTC0 to EPC or Status in the same cycle.
  - Ov_Req together with ERET in HANDLER: the exception wins and state stays EXL=1.
- Reset values:
  - Status=0, Cause=0, EPC=0, state IDLE.
  - Exc_Take=0, Flush=0, Exl=0.
  - rst asserted mid-TAKE returns to IDLE on the same edge, with no pulse in the next cycle.

## Configuration
- CP0_INT_EN defined: Int sampled into Cause.IP each cycle; interrupt path active.
- CP0_INT_EN undefined:
  - Int ignored; Cause.IP reads 0.
  - Only Ov/Sys exceptions are taken.
  - IE and IM remain writable but have no effect.

## Structure
- Para.v holds the shared constants:
  - `EXC_VECTOR and `CP0_PRID.
  - Register numbers CP0_STATUS/CAUSE/EPC/PRID.
  - ExcCodes EXC_INT/EXC_SYS/EXC_OV.
  - State encodings.
- One sub-module, cp0_regs: register file, MTC0 write masking and the MFC0 read mux.
- cp0_exc keeps priority selection, EPC computation and the FSM.

## Test plan
- Ov_Req=1, Ex_PC=0x0040_0010, Ex_BD=0:
  - Next cycle: Exc_Take=Flush=1, EPC=0x0040_0010, Cause.ExcCode=12, Exl=1.
  - Following cycle: Exc_Take=0.
- Sys_Req=1, Id_PC=0x0040_0024, Id_BD=1: EPC=0x0040_0020, Cause.BD=1, ExcCode=8.
- Ov_Req and Sys_Req together: ExcCode=12, EPC=Ex_PC.
- Then, in HANDLER, Sys_Req again: ExcCode=8, EPC unchanged.
- MTC0 Status=0x0000_0401, then Int[0]=1 with Ex_PC=0x0040_0100:
  - One cycle later: Exc_Take=1, ExcCode=0, EPC=0x0040_0100.
  - With CP0_INT_EN undefined: no Exc_Take, Cause reads 0.
- In HANDLER, ERET: Exl=0 next cycle; Int held high with IE=1 re-triggers TAKE one cycle later.
- rst asserted in TAKE cycle: next cycle all outputs 0 and state IDLE. MTC0 EPC=0x1234_5678 same cycle as Ov_Req: EPC=Ex_PC.

Source files
------------

// File: rtl/cp0_exc_pkg.sv
// Shared CP0 constants: handler vector, PRId, register numbers, ExcCodes and FSM states.
package cp0_exc_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
  localparam logic [31:0] CP0_PRID   = 32'h0001_8000;

  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID_REG = 5'd15;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_HANDLER = 2'd2
  } exc_state_e;

  // A delay-slot victim restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_exc_regs.sv
// CP0 register file (Status/Cause/EPC/PRId): MTC0 write masking, exception capture, MFC0 read mux.
module cp0_regs
  import cp0_exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        cap_i,
  input  logic        save_epc_i,
  input  logic [4:0]  code_i,
  input  logic [31:0] epc_i,
  input  logic        bd_i,
  input  logic        exl_i,
  input  logic [5:0]  ip_i,
  output logic [31:0] rdata_o,
  output logic [31:0] epc_o,
  output logic        ie_o,
  output logic [5:0]  im_o
);

  logic        ie_q, ie_d;
  logic [5:0]  im_q, im_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;

  // Exception capture has priority over any software write in the same cycle.
  always_comb begin
    ie_d   = ie_q;
    im_d   = im_q;
    code_d = code_q;
    bd_d   = bd_q;
    epc_d  = epc_q;
    if (cap_i) begin
      code_d = code_i;
      if (save_epc_i) begin
        epc_d = epc_i;
        bd_d  = bd_i;
      end else begin
        epc_d = epc_q;
      end
    end else if (wr_en_i) begin
      case (addr_i)
        CP0_STATUS: begin
          ie_d = wdata_i[0];
          im_d = wdata_i[15:10];
        end
        CP0_EPC: epc_d = wdata_i;
        default: epc_d = epc_q;
      endcase
    end else begin
      epc_d = epc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q   <= 1'b0;
      im_q   <= 6'd0;
      code_q <= 5'd0;
      bd_q   <= 1'b0;
      epc_q  <= 32'd0;
    end else begin
      ie_q   <= ie_d;
      im_q   <= im_d;
      code_q <= code_d;
      bd_q   <= bd_d;
      epc_q  <= epc_d;
    end
  end

  always_comb begin
    rdata_o = 32'd0;
    case (addr_i)
      CP0_STATUS:   rdata_o = {16'd0, im_q, 8'd0, exl_i, ie_q};
      CP0_CAUSE:    rdata_o = {bd_q, 15'd0, ip_i, 3'd0, code_q, 2'd0};
      CP0_EPC:      rdata_o = epc_q;
      CP0_PRID_REG: rdata_o = CP0_PRID;
      default:      rdata_o = 32'd0;
    endcase
  end

  assign epc_o = epc_q;
  assign ie_o  = ie_q;
  assign im_o  = im_q;

endmodule

// File: rtl/cp0_exc.sv
// CP0 exception controller: priority select, EPC computation and IDLE/TAKE/HANDLER FSM.
// Optional interrupt path enabled by defining CP0_INT_EN.
module cp0_exc
  import cp0_exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        Ov_Req,
  input  logic        Sys_Req,
  input  logic [31:0] Ex_PC,
  input  logic [31:0] Id_PC,
  input  logic        Ex_BD,
  input  logic        Id_BD,
  input  logic [5:0]  Int,
  input  logic        ERET,
  input  logic        Mtc0_En,
  input  logic [4:0]  Cp0_Addr,
  input  logic [31:0] Cp0_Wdata,
  output logic [31:0] Cp0_Rdata,
  output logic        Exc_Take,
  output logic [31:0] Exc_Vector,
  output logic        Flush,
  output logic [31:0] EPC,
  output logic        Exl
);

  exc_state_e  state_q, state_d;
  logic [5:0]  ip_s;
  logic [5:0]  im_s;
  logic        ie_s;
  logic        exl_s;
  logic        int_hit_s;
  logic        fire_s;
  logic        save_epc_s;
  logic        wr_en_s;
  logic [4:0]  code_s;
  logic [31:0] vpc_s;
  logic        vbd_s;

`ifdef CP0_INT_EN
  assign ip_s = Int;
`else
  assign ip_s = Int & 6'd0;
`endif

  assign exl_s     = (state_q != ST_IDLE);
  assign int_hit_s = ie_s & ~exl_s & (|(ip_s & im_s));

  // Oldest instruction wins: EX overflow, then ID syscall, then interrupt on EX.
  always_comb begin
    code_s = EXC_INT;
    vpc_s  = Ex_PC;
    vbd_s  = Ex_BD;
    if (Ov_Req) begin
      code_s = EXC_OV;
    end else if (Sys_Req) begin
      code_s = EXC_SYS;
      vpc_s  = Id_PC;
      vbd_s  = Id_BD;
    end else begin
      code_s = EXC_INT;
    end
  end

  always_comb begin
    state_d    = state_q;
    fire_s     = 1'b0;
    save_epc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Ov_Req | Sys_Req | int_hit_s) begin
          state_d    = ST_TAKE;
          fire_s     = 1'b1;
          save_epc_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TAKE: state_d = ST_HANDLER;
      // Nested exception keeps the original EPC so the first victim is resumed.
      ST_HANDLER: begin
        if (Ov_Req | Sys_Req) begin
          state_d = ST_TAKE;
          fire_s  = 1'b1;
        end else if (ERET) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HANDLER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign wr_en_s = Mtc0_En & (state_q != ST_TAKE) & ~fire_s;

  cp0_regs u_regs (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_s),
    .addr_i     (Cp0_Addr),
    .wdata_i    (Cp0_Wdata),
    .cap_i      (fire_s),
    .save_epc_i (save_epc_s),
    .code_i     (code_s),
    .epc_i      (epc_of(vpc_s, vbd_s)),
    .bd_i       (vbd_s),
    .exl_i      (exl_s),
    .ip_i       (ip_s),
    .rdata_o    (Cp0_Rdata),
    .epc_o      (EPC),
    .ie_o       (ie_s),
    .im_o       (im_s)
  );

  assign Exc_Take   = (state_q == ST_TAKE);
  assign Flush      = (state_q == ST_TAKE);
  assign Exl        = exl_s;
  assign Exc_Vector = EXC_VECTOR;

endmodule
